mem_stage: RTL
==============

# mem_stage

Memory-access stage between `ex_mem_reg` and `mem_wb_reg`. Turns EX/MEM control (`mem_read`, `word_we`, `byte_we`, `byte_load`) into a req/ack handshake with a multi-cycle data memory, and formats byte/word load data for `mem_wb_reg`. While an access is outstanding it raises `mem_stall` to freeze PC, IF/ID, ID/EX and EX/MEM, and converts the MEM/WB capture into a bubble.

## Interface
- `TIMEOUT`, 16: max BUSY cycles without `dmem_ack` before the access is abandoned (≥2).
- `clk`  in  1  clock, all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; one clock, no other reset.
- `write`  in  1  EX/MEM register-write enable.
- `mem_read`  in  1  EX/MEM load (MemToReg).
- `word_we`  in  1  EX/MEM word store.
- `byte_we`  in  1  EX/MEM byte store.
- `byte_load`  in  1  load is byte (1) or word (0).
- `aluOut`  in  32  effective address.
- `rtData`  in  32  store data.
- `dmem_rdata`  in  32  memory read data, valid with `dmem_ack`.
- `dmem_ack`  in  1  one-cycle access-complete pulse.
- `dmem_req`  out  1  access request, registered.
- `dmem_we`  out  1  store (1) / load (0), registered.
- `dmem_be`  out  4  byte enables, registered.
- `dmem_addr`  out  32  word-aligned address `{aluOut[31:2],2'b00}`, registered.
- `dmem_wdata`  out  32  store data, registered.
- `mem_data`  out  32  formatted load data to `mem_wb_reg`.
- `wb_write`  out  1  `write & ~mem_stall`, to `mem_wb_reg`.
- `mem_stall`  out  1  freeze upstream stages.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- `access = mem_read | word_we | byte_we`. If `mem_read` is set together with a store, the store takes priority.
- The FSM has three states: IDLE, BUSY, DONE.
  - IDLE: if `access`, latch `dmem_*` outputs, set `dmem_req=1`, go to BUSY. Otherwise stay in IDLE.
  - BUSY: hold `dmem_*` stable.
    - On `dmem_ack`: set `dmem_req=0`, capture formatted load data, go to DONE.
    - If the counter reaches `TIMEOUT-1` without ack: set `dmem_req=0`, load data = 0, set `bus_err`, go to DONE.
  - DONE: always go to IDLE. This state exists so that a held-then-released EX/MEM entry is not re-issued.
- `mem_stall = access & (state != DONE)`. This is combinational.
- Byte lanes are little-endian. `lane = aluOut[1:0]`.
  - Word store: `be=4'b1111`, wdata=`rtData`.
  - Byte store: `be = 4'b0001 << lane`, wdata = `{4{rtData[7:0]}}`.
  - Load: `be=4'b1111`. Word load returns `dmem_rdata`. Byte load returns `{24'b0, dmem_rdata[8*lane +: 8]}` (zero-extended).
  - For word accesses, `aluOut[1:0]` is ignored (address is aligned down).
- `mem_data` holds the last captured load value until the next capture. For a non-load access it is not updated.
- Reset (any time, including mid-BUSY): state goes to IDLE, and all outputs and registers are cleared to 0, including `bus_err`. Any ack arriving after reset is ignored.

## Timing
- Reset values: `dmem_req=0`, `dmem_we=0`, `dmem_be=0`, `dmem_addr=0`, `dmem_wdata=0`, `mem_data=0`, `bus_err=0`. `mem_stall` and `wb_write` follow their combinational inputs.
- Best case, ack in the first BUSY cycle:
  - Cycle 0 (IDLE): `mem_stall=1`.
  - Cycle 1 (BUSY): `dmem_req=1`, ack arrives.
  - Cycle 2 (DONE): `mem_stall=0`, `mem_data` valid, `wb_write=write`. `mem_wb_reg` captures at the end of cycle 2.
  - Total: 2 stall cycles.
- Each additional ack wait cycle adds one stall cycle.
- Timeout: DONE is entered after exactly `TIMEOUT` BUSY cycles.
- `dmem_req` is never high in IDLE or DONE. An ack seen outside BUSY is ignored.
- Back-to-back accesses: after DONE, the next EX/MEM entry is detected in IDLE on the following cycle.
- A non-access instruction passes through in zero added cycles (`mem_stall=0`).

## Structure
- `mem_stage_pkg` holds:
  - the state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the `BE_WORD=4'b1111` constant;
  - the byte-lane width.
- Sub-module `mem_lane_sel` is combinational. It takes lane, byte_load and store type, and produces `be`, replicated wdata and extracted load data. It is instantiated once.
- FSM, timeout counter (`$clog2(TIMEOUT)` bits) and output registers live in `mem_stage`.

## Test plan
- Word load, `aluOut=0x104`, ack in the first BUSY cycle with `rdata=0xDEADBEEF`:
  - `mem_stall` is high for exactly 2 cycles;
  - `dmem_addr=0x104`, `be=4'hF`;
  - `mem_data=0xDEADBEEF` in DONE;
  - `wb_write=1` only in DONE.
- Byte load, `aluOut=0x107`, `rdata=0x80112233`: `mem_data=0x00000080`.
- Byte store, `aluOut=0x202`, `rtData=0x000000A5`: `be=4'b0100`, `wdata=0xA5A5A5A5`, `dmem_we=1`.
- Store, ack delayed 5 cycles:
  - `dmem_req`, `addr`, `be` and `wdata` stay constant for all 5 cycles;
  - `mem_stall` lasts 6 cycles.
- No ack, `TIMEOUT=16`:
  - DONE is entered after 16 BUSY cycles;
  - `bus_err=1` and stays high;
  - `mem_data=0`.
- Reset asserted in the 2nd BUSY cycle, then a late ack:
  - all outputs go to 0 immediately;
  - state is IDLE;
  - the ack causes no capture and no state change.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared types and constants for the memory-access stage.
//            - state_t : access FSM encoding (IDLE / BUSY / DONE)
//            - BE_WORD : byte-enable pattern for full-word accesses
//            - BYTE_W  : width of one byte lane
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam int         BYTE_W  = 8;

endpackage
`default_nettype wire

// File: rtl/mem_lane_sel.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_sel
// Purpose  : Little-endian byte-lane steering for the memory stage (purely
//            combinational).
// Ports    : i_lane       - byte offset within the word (address[1:0])
//            i_byte_load  - load returns a single zero-extended byte
//            i_byte_store - store writes a single byte
//            i_store_data - register data to be stored
//            i_load_raw   - raw word returned by the memory
//            o_be         - byte enables for the request
//            o_wdata      - write data (byte replicated on all lanes)
//            o_load_data  - formatted load result
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_sel
  import mem_stage_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic        i_byte_load,
  input  logic        i_byte_store,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [BYTE_W-1:0] w_byte;

  always_comb begin
    o_be    = i_byte_store ? (4'b0001 << i_lane) : BE_WORD;
    // Replicating the byte lets the memory pick it up from whichever lane
    // the byte enable selects.
    o_wdata = i_byte_store ? {4{i_store_data[BYTE_W-1:0]}} : i_store_data;

    case (i_lane)
      2'd0:    w_byte = i_load_raw[0*BYTE_W +: BYTE_W];
      2'd1:    w_byte = i_load_raw[1*BYTE_W +: BYTE_W];
      2'd2:    w_byte = i_load_raw[2*BYTE_W +: BYTE_W];
      default: w_byte = i_load_raw[3*BYTE_W +: BYTE_W];
    endcase

    o_load_data = i_byte_load ? {{(32-BYTE_W){1'b0}}, w_byte} : i_load_raw;
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage. Converts EX/MEM load/store control into a
//            req/ack transaction with a multi-cycle data memory, stalls the
//            upstream pipeline while the access is outstanding and formats
//            load data for the MEM/WB register.
// Ports    : clk, reset (async, active-high)
//            write, mem_read, word_we, byte_we, byte_load, aluOut, rtData
//                                           - EX/MEM control and operands
//            dmem_rdata, dmem_ack           - memory response
//            dmem_req/we/be/addr/wdata      - registered memory request
//            mem_data, wb_write             - to MEM/WB register
//            mem_stall                      - freeze PC .. EX/MEM
//            bus_err                        - sticky access-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic        mem_read,
  input  logic        word_we,
  input  logic        byte_we,
  input  logic        byte_load,
  input  logic [31:0] aluOut,
  input  logic [31:0] rtData,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] mem_data,
  output logic        wb_write,
  output logic        mem_stall,
  output logic        bus_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem_data;
  logic              r_bus_err;

  logic              w_access;
  logic              w_store;
  logic              w_byte_store;
  logic              w_timeout;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;

  always_comb begin
    w_access     = mem_read | word_we | byte_we;
    // A store wins over a simultaneous mem_read; a word store wins over a
    // simultaneous byte store.
    w_store      = word_we | byte_we;
    w_byte_store = byte_we & ~word_we;
    w_timeout    = (r_cnt == CNT_LAST);
  end

  mem_lane_sel u_lane_sel (
    .i_lane       (aluOut[1:0]),
    .i_byte_load  (byte_load),
    .i_byte_store (w_byte_store),
    .i_store_data (rtData),
    .i_load_raw   (dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_access) w_next_state = ST_BUSY;
      ST_BUSY: if (dmem_ack || w_timeout) w_next_state = ST_DONE;
      // DONE lasts one cycle so that the EX/MEM entry still presented while
      // the stall releases is not issued a second time.
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------- request / response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_mem_data <= 32'd0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_req   <= 1'b1;
            r_we    <= w_store;
            r_be    <= w_store ? w_be : BE_WORD;
            r_addr  <= {aluOut[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_mem_data <= w_load_data;
          end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
            if (!r_we) r_mem_data <= 32'd0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dmem_req   = r_req;
    dmem_we    = r_we;
    dmem_be    = r_be;
    dmem_addr  = r_addr;
    dmem_wdata = r_wdata;
    mem_data   = r_mem_data;
    bus_err    = r_bus_err;
    mem_stall  = w_access & (r_state != ST_DONE);
    wb_write   = write & ~mem_stall;
  end

endmodule
`default_nettype wire
